// File: rtl/imem_loader_if.sv
// Host byte-stream handshake and instruction-memory write port used by imem_loader.
interface imem_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: turns a length-prefixed big-endian byte stream into instruction-memory writes.
// Define IMEM_LOADER_CKSUM_EN to require a trailing XOR checksum byte.
module imem_loader #(
  parameter int unsigned DEPTH = 256
) (
  input  logic         clk,
  input  logic         clear_n,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         done,
  output logic         err
);

  typedef enum logic [3:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StDataHi,
    StDataLo,
`ifdef IMEM_LOADER_CKSUM_EN
    StCksum,
`endif
    StFinish,
    StDone,
    StErr
  } state_e;

`ifdef IMEM_LOADER_CKSUM_EN
  localparam state_e StTail = StCksum;
`else
  localparam state_e StTail = StFinish;
`endif

  state_e      state, state_d;
  logic [7:0]  hi_byte;
  logic [15:0] len, word_cnt, len_rx;
  logic        xfer, can_start;
`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0]  cksum;
`endif

  assign xfer      = bus.byte_valid & bus.byte_ready;
  assign len_rx    = {hi_byte, bus.byte_data};
  assign can_start = start & (state inside {StIdle, StDone, StErr});

  always_comb begin
    state_d = state;
    case (state)
      StIdle, StDone, StErr: if (start) state_d = StLenHi;
      StLenHi:  if (xfer) state_d = StLenLo;
      StLenLo: begin
        if (xfer) begin
          // Length is validated here so no write can ever land beyond DEPTH-1.
          if (len_rx == 16'd0)            state_d = StTail;
          else if (32'(len_rx) > DEPTH)   state_d = StErr;
          else                            state_d = StDataHi;
        end
      end
      StDataHi: if (xfer) state_d = StDataLo;
      StDataLo: if (xfer) state_d = (word_cnt + 16'd1 == len) ? StTail : StDataHi;
`ifdef IMEM_LOADER_CKSUM_EN
      StCksum:  if (xfer) state_d = (bus.byte_data == cksum) ? StFinish : StErr;
`endif
      StFinish: state_d = StDone;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state          <= StIdle;
      bus.byte_ready <= 1'b0;
      cpu_hold       <= 1'b1;
      done           <= 1'b0;
      err            <= 1'b0;
      hi_byte        <= 8'd0;
      len            <= 16'd0;
      word_cnt       <= 16'd0;
      bus.wr_en      <= 1'b0;
      bus.wr_addr    <= 16'd0;
      bus.wr_data    <= 16'd0;
`ifdef IMEM_LOADER_CKSUM_EN
      cksum          <= 8'd0;
`endif
    end else begin
      state <= state_d;
      // Status outputs are decoded from the next state so they are flop outputs.
      bus.byte_ready <= state_d inside {StLenHi, StLenLo, StDataHi, StDataLo
`ifdef IMEM_LOADER_CKSUM_EN
                                        , StCksum
`endif
                                        };
      cpu_hold  <= (state_d != StDone);
      done      <= (state_d == StDone);
      err       <= (state_d == StErr);
      bus.wr_en <= 1'b0;

      if (can_start) begin
        word_cnt <= 16'd0;
`ifdef IMEM_LOADER_CKSUM_EN
        cksum    <= 8'd0;
`endif
      end

      if (xfer) begin
        case (state)
          StLenHi, StDataHi: hi_byte <= bus.byte_data;
          StLenLo:           len <= len_rx;
          StDataLo: begin
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= word_cnt;
            bus.wr_data <= {hi_byte, bus.byte_data};
            word_cnt    <= word_cnt + 16'd1;
          end
          default: ;
        endcase
`ifdef IMEM_LOADER_CKSUM_EN
        if (state inside {StLenHi, StLenLo, StDataHi, StDataLo}) cksum <= cksum ^ bus.byte_data;
`endif
      end
    end
  end

endmodule
